// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-decoder memory bridge.
package mem_bridge_pkg;

  // Width of the wait-state counter; covers WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

endpackage

// File: rtl/mem_bridge.sv
// Memory bridge: latches one CPU request, drives it to the address decoder
// for a fixed number of cycles, returns a one-cycle ready pulse, and records
// unmapped accesses in a sticky error register.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dec_addr,
  output logic [31:0] dec_wdata,
  output logic [3:0]  dec_wstrb,
  input  logic [31:0] dec_rdata,
  input  logic        dec_ready,
  output logic        err,
  output logic [31:0] err_addr,
  output logic        err_instr,
  input  logic        err_clr
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      addr_reg, wdata_reg, rdata_reg;
  logic [3:0]       wstrb_reg;
  logic             instr_reg;
  logic             err_reg, err_instr_reg;
  logic [31:0]      err_addr_reg;
  logic             latch_en, capture_en, err_set;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next state, counter load, strobe gating and response outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    err_set    = 1'b0;
    cpu_ready  = 1'b0;
    cpu_rdata  = 32'h0;
    dec_wstrb  = 4'h0;
    case (state_reg)
      S_IDLE: begin
        if (cpu_valid) begin
          latch_en   = 1'b1;
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!dec_ready) begin
          err_set    = 1'b1;
          state_next = S_ERR;
        end else begin
          // The only cycle a write reaches memory.
          dec_wstrb = wstrb_reg;
          if (WAIT_STATES == 0) begin
            capture_en = 1'b1;
            state_next = S_RESP;
          end else begin
            cnt_next   = CNT_W'(WAIT_STATES - 1);
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == '0) begin
          capture_en = 1'b1;
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_RESP: begin
        cpu_ready  = 1'b1;
        cpu_rdata  = rdata_reg;
        state_next = S_IDLE;
      end
      S_ERR: begin
        cpu_ready  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request latches, wait counter and read-data capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg   <= '0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      wstrb_reg <= 4'h0;
      instr_reg <= 1'b0;
      rdata_reg <= 32'h0;
    end else begin
      cnt_reg <= cnt_next;
      if (latch_en) begin
        addr_reg  <= cpu_addr;
        wdata_reg <= cpu_wdata;
        wstrb_reg <= cpu_wstrb;
        instr_reg <= cpu_instr;
      end
      // Writes return zero; reads take the decoder data on the last access cycle.
      if (capture_en) rdata_reg <= (wstrb_reg == 4'h0) ? dec_rdata : 32'h0;
    end
  end

  // Sticky error flag; a new error takes priority over a coincident clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_reg       <= 1'b0;
      err_addr_reg  <= 32'h0;
      err_instr_reg <= 1'b0;
    end else if (err_set) begin
      err_reg       <= 1'b1;
      err_addr_reg  <= addr_reg;
      err_instr_reg <= instr_reg;
    end else if (err_clr && state_reg != S_ERR) begin
      err_reg <= 1'b0;
    end
  end

  assign dec_addr  = addr_reg;
  assign dec_wdata = wdata_reg;
  assign err       = err_reg;
  assign err_addr  = err_addr_reg;
  assign err_instr = err_instr_reg;

endmodule
